// File: rtl/clock_gen.sv
// Multi-channel clock divider: NUM_CH independent, glitch-free divided clocks derived from clk_i.
// Each channel has its own divide ratio, tick strobe, status flag and optional sticky lock.
module clock_gen #(
   parameter int unsigned          NUM_CH    = 3,
   parameter int unsigned          DIV_W     = 8,
   parameter logic [NUM_CH-1:0]    LOCK_MASK = '0
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic [NUM_CH-1:0]       ch_enable_i,
   input  logic [NUM_CH*DIV_W-1:0] ch_div_i,
   output logic [NUM_CH-1:0]       ch_clk_o,
   output logic [NUM_CH-1:0]       ch_tick_o,
   output logic [NUM_CH-1:0]       ch_active_o
);

   typedef enum logic [1:0] {StOff, StRun, StStopping} ch_state_e;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_e        st_q;
      logic [DIV_W-1:0] cnt_q;
      logic [DIV_W-1:0] div_q;
      logic             lock_q;
      logic             clk_q;
      logic             tick_q;
      logic             active_q;

      logic [DIV_W-1:0] div_in;
      logic             wrap;
      logic             run_en;

      assign div_in = ch_div_i[i*DIV_W +: DIV_W];
      assign wrap   = (cnt_q == div_q);
      assign run_en = ch_enable_i[i] | lock_q;

      always_ff @(posedge clk_i or negedge reset_ni) begin
         if (!reset_ni) begin
            st_q     <= StOff;
            cnt_q    <= '0;
            div_q    <= '0;
            lock_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
         end else begin
            tick_q <= 1'b0;
            case (st_q)
               StOff: begin
                  cnt_q    <= '0;
                  clk_q    <= 1'b0;
                  active_q <= 1'b0;
                  if (ch_enable_i[i]) begin
                     st_q     <= StRun;
                     div_q    <= div_in;
                     lock_q   <= LOCK_MASK[i];
                     active_q <= 1'b1;
                  end
               end
               StRun, StStopping: begin
                  if (!run_en && !clk_q) begin
                     // Low phase may be cut short: the output is already 0, so no glitch.
                     st_q     <= StOff;
                     cnt_q    <= '0;
                     active_q <= 1'b0;
                  end else if (wrap) begin
                     cnt_q <= '0;
                     clk_q <= ~clk_q;
                     if (!clk_q) begin
                        tick_q <= 1'b1;
                     end else begin
                        // Falling edge: new ratio takes effect; active_q lingers one cycle.
                        div_q <= div_in;
                        st_q  <= run_en ? StRun : StOff;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     st_q  <= run_en ? StRun : StStopping;
                  end
               end
               default: st_q <= StOff;
            endcase
         end
      end

      assign ch_clk_o[i]    = clk_q;
      assign ch_tick_o[i]   = tick_q;
      assign ch_active_o[i] = active_q;
   end

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: reset, divide ratios, ratio change, disable paths, lock.
module tb_clock_gen;

   logic        clk;
   logic        reset_n;
   logic [2:0]  en;
   logic [23:0] div;
   logic [2:0]  ch_clk;
   logic [2:0]  ch_tick;
   logic [2:0]  ch_active;

   int checks = 0;
   int errors = 0;

   clock_gen #(
      .NUM_CH   (3),
      .DIV_W    (8),
      .LOCK_MASK(3'b100)
   ) dut (
      .clk_i      (clk),
      .reset_ni   (reset_n),
      .ch_enable_i(en),
      .ch_div_i   (div),
      .ch_clk_o   (ch_clk),
      .ch_tick_o  (ch_tick),
      .ch_active_o(ch_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      en      = '0;
      div     = '0;

      // 1: outputs held low during reset regardless of inputs
      for (int k = 0; k < 6; k++) begin
         en  = 3'($urandom_range(7, 0));
         div = 24'($urandom());
         cyc(1);
         chk("rst_clk", 32'(ch_clk), 32'h0);
         chk("rst_tick", 32'(ch_tick), 32'h0);
         chk("rst_active", 32'(ch_active), 32'h0);
      end
      en      = '0;
      div     = '0;
      reset_n = 1'b1;
      cyc(3);
      chk("idle_clk", 32'(ch_clk), 32'h0);
      chk("idle_active", 32'(ch_active), 32'h0);

      // 2: channel 0, div 0 -> clk/2
      en[0] = 1'b1;
      cyc(1);
      chk("c0_active", 32'(ch_active), 32'h1);
      chk("c0_first_low", 32'(ch_clk[0]), 32'h0);
      cyc(1);
      chk("c0_rise1", 32'(ch_clk[0]), 32'h1);
      chk("c0_tick1", 32'(ch_tick[0]), 32'h1);
      cyc(1);
      chk("c0_fall1", 32'(ch_clk[0]), 32'h0);
      chk("c0_tick_off", 32'(ch_tick[0]), 32'h0);
      cyc(1);
      chk("c0_rise2", 32'(ch_clk[0]), 32'h1);
      chk("c0_tick2", 32'(ch_tick[0]), 32'h1);
      cyc(1);
      chk("c0_fall2", 32'(ch_clk[0]), 32'h0);
      en[0] = 1'b0;
      cyc(1);
      chk("c0_off_active", 32'(ch_active[0]), 32'h0);
      chk("c0_off_clk", 32'(ch_clk[0]), 32'h0);
      cyc(1);
      chk("c0_off_tick", 32'(ch_tick[0]), 32'h0);

      // 3: channel 1, div 3, then div 1 written mid high phase
      div[15:8] = 8'd3;
      en[1]     = 1'b1;
      cyc(1);
      chk("c1_active", 32'(ch_active), 32'h2);
      cyc(3);
      chk("c1_low_end", 32'(ch_clk[1]), 32'h0);
      cyc(1);
      chk("c1_rise", 32'(ch_clk[1]), 32'h1);
      chk("c1_tick", 32'(ch_tick[1]), 32'h1);
      cyc(1);
      chk("c1_high2", 32'(ch_clk[1]), 32'h1);
      chk("c1_tick_off", 32'(ch_tick[1]), 32'h0);
      div[15:8] = 8'd1;
      cyc(2);
      chk("c1_high4", 32'(ch_clk[1]), 32'h1);
      cyc(1);
      chk("c1_fall", 32'(ch_clk[1]), 32'h0);
      cyc(1);
      chk("c1_d1_low2", 32'(ch_clk[1]), 32'h0);
      cyc(1);
      chk("c1_d1_rise", 32'(ch_clk[1]), 32'h1);
      chk("c1_d1_tick", 32'(ch_tick[1]), 32'h1);
      cyc(1);
      chk("c1_d1_high2", 32'(ch_clk[1]), 32'h1);
      cyc(1);
      chk("c1_d1_fall", 32'(ch_clk[1]), 32'h0);

      // 4a: disable in low phase -> OFF next cycle
      en[1] = 1'b0;
      cyc(1);
      chk("c1_lowdis_active", 32'(ch_active[1]), 32'h0);
      chk("c1_lowdis_clk", 32'(ch_clk[1]), 32'h0);

      // 4b: disable one cycle into the high phase -> high phase completes
      div[15:8] = 8'd3;
      en[1]     = 1'b1;
      cyc(5);
      chk("c1_b_rise", 32'(ch_clk[1]), 32'h1);
      en[1] = 1'b0;
      cyc(3);
      chk("c1_stop_high", 32'(ch_clk[1]), 32'h1);
      chk("c1_stop_active", 32'(ch_active[1]), 32'h1);
      chk("c1_stop_tick", 32'(ch_tick[1]), 32'h0);
      cyc(1);
      chk("c1_stop_fall", 32'(ch_clk[1]), 32'h0);
      chk("c1_stop_linger", 32'(ch_active[1]), 32'h1);
      chk("c1_stop_tick2", 32'(ch_tick[1]), 32'h0);
      cyc(1);
      chk("c1_stop_off", 32'(ch_active[1]), 32'h0);

      // 5: re-enable while STOPPING -> uninterrupted 8-cycle periods
      en[1] = 1'b1;
      cyc(5);
      chk("c1_c_rise", 32'(ch_clk[1]), 32'h1);
      en[1] = 1'b0;
      cyc(1);
      chk("c1_c_stopping", 32'(ch_clk[1]), 32'h1);
      en[1] = 1'b1;
      cyc(2);
      chk("c1_c_high4", 32'(ch_clk[1]), 32'h1);
      cyc(1);
      chk("c1_c_fall", 32'(ch_clk[1]), 32'h0);
      chk("c1_c_active", 32'(ch_active[1]), 32'h1);
      cyc(3);
      chk("c1_c_low4", 32'(ch_clk[1]), 32'h0);
      cyc(1);
      chk("c1_c_rise2", 32'(ch_clk[1]), 32'h1);
      chk("c1_c_tick2", 32'(ch_tick[1]), 32'h1);
      cyc(4);
      chk("c1_c_fall2", 32'(ch_clk[1]), 32'h0);

      // 6: locked channel 2 ignores disable; only reset stops it
      div[23:16] = 8'd7;
      en[2]      = 1'b1;
      cyc(1);
      chk("c2_active", 32'(ch_active[2]), 32'h1);
      en[2] = 1'b0;
      cyc(7);
      chk("c2_low8", 32'(ch_clk[2]), 32'h0);
      chk("c2_locked_active", 32'(ch_active[2]), 32'h1);
      cyc(1);
      chk("c2_rise", 32'(ch_clk[2]), 32'h1);
      chk("c2_tick", 32'(ch_tick[2]), 32'h1);
      cyc(7);
      chk("c2_high8", 32'(ch_clk[2]), 32'h1);
      cyc(1);
      chk("c2_fall", 32'(ch_clk[2]), 32'h0);
      cyc(7);
      chk("c2_low8b", 32'(ch_clk[2]), 32'h0);
      cyc(1);
      chk("c2_rise2", 32'(ch_clk[2]), 32'h1);
      chk("c2_tick2", 32'(ch_tick[2]), 32'h1);
      cyc(2);
      chk("c2_mid_high", 32'(ch_clk[2]), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_clk", 32'(ch_clk), 32'h0);
      chk("async_rst_active", 32'(ch_active), 32'h0);
      chk("async_rst_tick", 32'(ch_tick), 32'h0);
      cyc(1);
      en      = '0;
      reset_n = 1'b1;
      cyc(3);
      chk("post_rst_active", 32'(ch_active), 32'h0);
      chk("post_rst_clk", 32'(ch_clk), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_gen.md
Name: clock_gen

Overview:
Parametrised multi-channel clock generator. It is the successor to the single-output clock block with fixed clk/lsi/wdt outputs. It derives NUM_CH independent divided clocks from one system clock. Each channel has a programmable divide ratio, glitch-free enable/disable, a per-rising-edge tick strobe and a status flag. Channels selected by LOCK_MASK become sticky once enabled and can only be stopped by reset, for watchdog-style clock sources. It sits between the system oscillator and peripheral clock consumers such as timers and the watchdog.

Parameters:
NUM_CH, 3, number of output clock channels (1..16)
DIV_W, 8, width of each channel's divide field
LOCK_MASK, 0, bit i=1: channel i ignores enable deassertion once started

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally
ch_enable  input  NUM_CH  per-channel run request, level-sensitive
ch_div  input  NUM_CH*DIV_W  per-channel half-period minus one; channel i at bits [i*DIV_W +: DIV_W]
ch_clk  output  NUM_CH  divided clock outputs, registered
ch_tick  output  NUM_CH  one-cycle strobe, high in the cycle ch_clk[i] goes 0->1
ch_active  output  NUM_CH  1 while channel state != OFF

Behaviour:
- Reset (reset=0): asynchronous. All ch_clk=0, ch_tick=0, ch_active=0. Counters=0, states=OFF, lock flags cleared. Applies mid-operation with no phase completion.
- Per-channel state machine: OFF, RUN, STOPPING. Each channel has cnt[DIV_W-1:0], div_q[DIV_W-1:0] and a lock flag.
- OFF: ch_clk=0, cnt=0. If ch_enable=1, go to RUN next cycle, latch div_q<=ch_div[i], set lock if LOCK_MASK[i].
- RUN and STOPPING counting: if cnt==div_q, set cnt<=0 and toggle ch_clk; otherwise cnt<=cnt+1.
- Half-period: each phase lasts div_q+1 cycles, so the period is 2*(div_q+1) with 50% duty. div=0 gives clk/2.
- First rising edge of ch_clk occurs div_q+1 cycles after entering RUN; the initial low phase is a full phase.
- div_q reloads from ch_div only on the 1->0 toggle and on OFF->RUN. A change to ch_div mid-period never alters the current period.
- Disable in RUN (ch_enable=0, lock=0):
  - ch_clk=0: go to OFF next cycle and clear cnt. The low phase may be truncated; this is glitch-free.
  - ch_clk=1: go to STOPPING. The high phase completes in full. On its 1->0 toggle go to OFF, not RUN.
- STOPPING with ch_enable=1 again: return to RUN with no gap or phase disturbance.
- Locked channel: ch_enable deassertion is ignored and the channel stays in RUN until reset.
- ch_tick: registered, asserted exactly in the cycle ch_clk becomes 1. Never asserted in OFF or at disable.
- ch_active: low only in OFF. It falls in the cycle after the final 1->0 toggle, or after the OFF transition when low.
- Channels are fully independent. Simultaneous enable/disable on different channels has no interaction.
- No combinational paths from inputs to outputs.

Test Plan:
1. Hold reset=0 with random ch_enable/ch_div -> ch_clk=ch_tick=ch_active=3'b000 throughout. Release reset with all enables at 0 -> outputs stay 0.
2. Channel 0 with ch_div=0, enable=1 -> ch_active[0]=1 next cycle; ch_clk[0] rises 1 cycle later, then period 2; ch_tick[0] pulses every 2 cycles for 1 cycle.
3. Channel 1 with ch_div=3 -> 4 cycles low, 4 high, period 8. Write ch_div=1 mid high phase -> current high phase stays 4; following periods are 2 low / 2 high.
4. Channel 1 with div=3, deassert enable 1 cycle into the high phase -> ch_clk stays 1 for 3 more cycles then 0; ch_active drops 1 cycle later; no tick. Deassert during the low phase -> ch_clk stays 0; ch_active=0 next cycle.
5. Channel 1 in STOPPING, re-assert enable before the high phase ends -> continuous 8-cycle periods with no stretched or shortened phase.
6. LOCK_MASK=3'b100, enable channel 2 (div=7) then deassert -> keeps toggling with period 16. Pulse reset low mid-high -> ch_clk[2]=0 immediately. After reset release with enable=0 -> channel 2 remains OFF.
